// File: rtl/bus_pkg.sv
// bus_pkg: shared access-size encodings, controller FSM states and alignment helper
// Used by bus_mem_ctrl and bus_lane_align via import bus_pkg::*.
package bus_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, DONE, ERR} busState;
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    return (size == SZ_HALF && addrLo[0]) || (size == SZ_WORD && addrLo != 2'b00);
  endfunction
endpackage

// File: rtl/bus_lane_align.sv
// bus_lane_align: combinational byte-lane steering between the core bus and a 32-bit memory
// Ports: size/addrLo describe the access; storeData -> byteEn/storeLanes for writes;
//        loadWord (raw memory word) -> loadData (shifted, zero-extended) for reads.
module bus_lane_align
  import bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addrLo,
  input  logic [31:0] storeData,
  input  logic [31:0] loadWord,
  output logic [3:0]  byteEn,
  output logic [31:0] storeLanes,
  output logic [31:0] loadData
);
  logic [1:0]  lo;
  logic [31:0] shifted;
  always_comb begin
    // low bits that cannot be honoured for the access size are ignored
    lo = size == SZ_WORD ? 2'b00 : size == SZ_HALF ? {addrLo[1], 1'b0} : addrLo;
    byteEn = size == SZ_BYTE ? 4'b0001 << lo :
             size == SZ_HALF ? (lo[1] ? 4'b1100 : 4'b0011) :
             size == SZ_WORD ? 4'b1111 : 4'b0000;
    storeLanes = size == SZ_BYTE ? {4{storeData[7:0]}} :
                 size == SZ_HALF ? {2{storeData[15:0]}} : storeData;
    shifted = loadWord >> {lo, 3'b000};
    loadData = size == SZ_BYTE ? {24'h0, shifted[7:0]} :
               size == SZ_HALF ? {16'h0, shifted[15:0]} : shifted;
  end
endmodule

// File: rtl/bus_mem_ctrl.sv
// bus_mem_ctrl: single-outstanding core-bus to synchronous 32-bit memory controller
// Core side : addr, wdata, rd, wr, size in; rdata, ready (done pulse), error (fault pulse) out.
// Memory    : mem_addr (word index), mem_wdata, mem_be, mem_we, mem_re out; mem_rdata in,
//             valid LATENCY cycles after mem_re.
// Build option: define MISALIGN_TRAP_EN to fault misaligned halfword/word accesses
//               instead of silently clearing the offending address bits.
module bus_mem_ctrl
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 16384,
  parameter int          LATENCY     = 1,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  input  logic          rd,
  input  logic          wr,
  input  logic [1:0]    size,
  output logic [31:0]   rdata,
  output logic          ready,
  output logic          error,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [31:0]   mem_rdata
);
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  busState       state, nextState;
  logic [AW-1:0] idxQ;
  logic [1:0]    loQ, sizeQ, cnt;
  logic [31:0]   wdataQ, off, lanes, loadData;
  logic [3:0]    be;
  logic          writeQ, accept, inRange, bad, acc;
  always_comb begin
    off = addr - BASE_ADDR;
    // power-of-two window: anything above the index bits is out of range
    inRange = addr >= BASE_ADDR && (off >> (AW + 2)) == 32'd0;
    bad = (rd && wr) || size == 2'b11 || !inRange || (TRAP && isMisaligned(size, addr[1:0]));
    accept = state == IDLE && (rd || wr);
  end
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = accept ? (bad ? ERR : ACCESS) : IDLE;
      ACCESS:  nextState = writeQ ? DONE : WAIT;
      WAIT:    nextState = cnt == 2'd0 ? DONE : WAIT;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idxQ   <= '0;
      loQ    <= 2'b00;
      sizeQ  <= 2'b00;
      wdataQ <= 32'h0;
      writeQ <= 1'b0;
      cnt    <= 2'd0;
      rdata  <= 32'h0;
    end else begin
      state <= nextState;
      if (accept) begin
        idxQ   <= off[AW+1:2];
        loQ    <= addr[1:0];
        sizeQ  <= size;
        wdataQ <= wdata;
        writeQ <= wr;
      end
      if (state == ACCESS) cnt <= 2'(LATENCY - 1);
      else if (state == WAIT) cnt <= cnt - 2'd1;
      if (state == WAIT && cnt == 2'd0) rdata <= loadData;
    end
  end
  bus_lane_align laneAlign (
    .size      (sizeQ),
    .addrLo    (loQ),
    .storeData (wdataQ),
    .loadWord  (mem_rdata),
    .byteEn    (be),
    .storeLanes(lanes),
    .loadData  (loadData)
  );
  // memory strobes and their qualifiers exist only during the single ACCESS cycle
  assign acc       = state == ACCESS;
  assign mem_we    = acc && writeQ;
  assign mem_re    = acc && !writeQ;
  assign mem_be    = acc ? be : 4'h0;
  assign mem_wdata = acc ? lanes : 32'h0;
  assign mem_addr  = acc ? idxQ : '0;
  assign ready     = state == DONE || state == ERR;
  assign error     = state == ERR;
endmodule

// File: tb/tb_bus_mem_ctrl.sv
// tb_bus_mem_ctrl: directed self-checking bench for bus_mem_ctrl (LATENCY 1 and LATENCY 4 instances)
module tb_bus_mem_ctrl;
  import bus_pkg::*;
  logic        clk = 0, rst = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [1:0]  size = 0;
  logic        rd = 0, wr = 0, rd4 = 0, wr4 = 0;
  logic [31:0] rdata, memWdata, memRdata, rdata4, memWdata4, memRdata4;
  logic        ready, error, memWe, memRe, ready4, error4, memWe4, memRe4;
  logic [3:0]  memBe, memBe4;
  logic [3:0]  memAddr;
  logic [13:0] memAddr4;
  logic [31:0] mem [16];
  logic [31:0] pipe4 [4];
  int checks = 0, errors = 0;
  logic [31:0] expRdata;

  always #5 clk = ~clk;

  bus_mem_ctrl #(.BASE_ADDR(32'h0), .DEPTH_WORDS(16), .LATENCY(1)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rd(rd), .wr(wr), .size(size),
    .rdata(rdata), .ready(ready), .error(error), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_be(memBe), .mem_we(memWe), .mem_re(memRe), .mem_rdata(memRdata)
  );

  bus_mem_ctrl #(.BASE_ADDR(32'h1000), .DEPTH_WORDS(16384), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rd(rd4), .wr(wr4), .size(size),
    .rdata(rdata4), .ready(ready4), .error(error4), .mem_addr(memAddr4), .mem_wdata(memWdata4),
    .mem_be(memBe4), .mem_we(memWe4), .mem_re(memRe4), .mem_rdata(memRdata4)
  );

  // one-cycle synchronous RAM with byte enables
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) if (memWe && memBe[b]) mem[memAddr][8*b +: 8] <= memWdata[8*b +: 8];
    if (memRe) memRdata <= mem[memAddr];
  end

  // four-cycle pipeline returning a tag of the sampled word index
  always @(posedge clk) begin
    pipe4[0] <= 32'hC0DE_0000 | {18'b0, memAddr4};
    for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
  end
  assign memRdata4 = pipe4[3];

  task automatic issue(input bit four, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] s);
    @(posedge clk); #1;
    addr = a; wdata = d; size = s;
    if (four) begin rd4 = r; wr4 = w; end else begin rd = r; wr = w; end
    @(posedge clk); #1;
    rd = 0; wr = 0; rd4 = 0; wr4 = 0;
  endtask

  task automatic waitReady(input bit four, output int cyc);
    cyc = 1;
    while (!(four ? ready4 : ready) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, error, memWe, memRe, memBe, memAddr, memWdata, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b error=%b we=%b re=%b be=%h addr=%h wdata=%h rdata=%h, expected all 0",
               ready, error, memWe, memRe, memBe, memAddr, memWdata, rdata);
    end
    checks++;
    if ({ready4, error4, memWe4, memRe4, memBe4, memAddr4, memWdata4, rdata4} !== '0) begin
      errors++;
      $display("FAIL reset_outputs4: got ready=%b error=%b we=%b re=%b be=%h addr=%h wdata=%h rdata=%h, expected all 0",
               ready4, error4, memWe4, memRe4, memBe4, memAddr4, memWdata4, rdata4);
    end
    @(negedge clk) rst = 0;
  endtask

  task automatic test_write_word;
    int cyc;
    issue(0, 0, 1, 32'h10, 32'hDEADBEEF, SZ_WORD);
    checks++;
    if ({memWe, memRe, memBe, memAddr, memWdata} !== {1'b1, 1'b0, 4'hF, 4'h4, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL wr_word_strobe: got we=%b re=%b be=%h addr=%h wdata=%h, expected we=1 re=0 be=f addr=4 wdata=deadbeef",
               memWe, memRe, memBe, memAddr, memWdata);
    end
    waitReady(0, cyc);
    checks++;
    if (cyc !== 2 || error !== 1'b0) begin
      errors++;
      $display("FAIL wr_word_ready: got ready at cycle %0d error=%b, expected cycle 2 error=0", cyc, error);
    end
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_word_pulse: got ready=%b one cycle later, expected 0", ready);
    end
  endtask

  task automatic test_read_word;
    int cyc;
    issue(0, 1, 0, 32'h10, 32'h0, SZ_WORD);
    checks++;
    if ({memRe, memWe, memAddr} !== {1'b1, 1'b0, 4'h4}) begin
      errors++;
      $display("FAIL rd_word_strobe: got re=%b we=%b addr=%h, expected re=1 we=0 addr=4", memRe, memWe, memAddr);
    end
    waitReady(0, cyc);
    checks++;
    if (cyc !== 3 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_word: got ready at cycle %0d rdata=%h, expected cycle 3 rdata=deadbeef", cyc, rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_word_hold: got ready=%b rdata=%h, expected ready=0 rdata=deadbeef", ready, rdata);
    end
  endtask

  task automatic test_byte_write;
    int cyc;
    issue(0, 0, 1, 32'h13, 32'h0000_00A5, SZ_BYTE);
    checks++;
    if ({memBe, memWdata, memAddr} !== {4'b1000, 32'hA5A5A5A5, 4'h4}) begin
      errors++;
      $display("FAIL wr_byte_lanes: got be=%b wdata=%h addr=%h, expected be=1000 wdata=a5a5a5a5 addr=4", memBe, memWdata, memAddr);
    end
    waitReady(0, cyc);
    issue(0, 1, 0, 32'h10, 32'h0, SZ_WORD);
    waitReady(0, cyc);
    checks++;
    if (cyc !== 3 || rdata !== 32'hA5ADBEEF) begin
      errors++;
      $display("FAIL rd_after_byte: got cycle %0d rdata=%h, expected cycle 3 rdata=a5adbeef", cyc, rdata);
    end
  endtask

  task automatic test_subword_read;
    int cyc;
    issue(0, 0, 1, 32'h20, 32'h8001_7FFF, SZ_WORD);
    waitReady(0, cyc);
    issue(0, 1, 0, 32'h22, 32'h0, SZ_HALF);
    waitReady(0, cyc);
    checks++;
    if (cyc !== 3 || rdata !== 32'h0000_8001) begin
      errors++;
      $display("FAIL rd_half_hi: got cycle %0d rdata=%h, expected cycle 3 rdata=00008001", cyc, rdata);
    end
    issue(0, 1, 0, 32'h20, 32'h0, SZ_HALF);
    waitReady(0, cyc);
    checks++;
    if (rdata !== 32'h0000_7FFF) begin
      errors++;
      $display("FAIL rd_half_lo: got rdata=%h, expected 00007fff", rdata);
    end
    issue(0, 1, 0, 32'h21, 32'h0, SZ_BYTE);
    waitReady(0, cyc);
    checks++;
    if (rdata !== 32'h0000_007F) begin
      errors++;
      $display("FAIL rd_byte1: got rdata=%h, expected 0000007f", rdata);
    end
    issue(0, 0, 1, 32'h16, 32'h0000_1234, SZ_HALF);
    checks++;
    if ({memBe, memWdata, memAddr} !== {4'b1100, 32'h12341234, 4'h5}) begin
      errors++;
      $display("FAIL wr_half_lanes: got be=%b wdata=%h addr=%h, expected be=1100 wdata=12341234 addr=5", memBe, memWdata, memAddr);
    end
    waitReady(0, cyc);
  endtask

  task automatic test_misaligned;
    int cyc;
    issue(0, 1, 0, 32'h11, 32'h0, SZ_WORD);
`ifdef MISALIGN_TRAP_EN
    checks++;
    if ({error, ready, memRe, memWe} !== 4'b1100 || rdata !== 32'h0000_007F) begin
      errors++;
      $display("FAIL misaligned_trap: got error=%b ready=%b re=%b we=%b rdata=%h, expected 1 1 0 0 rdata=0000007f",
               error, ready, memRe, memWe, rdata);
    end
    expRdata = 32'h0000_007F;
`else
    checks++;
    if ({memRe, memAddr} !== {1'b1, 4'h4}) begin
      errors++;
      $display("FAIL misaligned_strobe: got re=%b addr=%h, expected re=1 addr=4", memRe, memAddr);
    end
    waitReady(0, cyc);
    checks++;
    if (cyc !== 3 || error !== 1'b0 || rdata !== 32'hA5ADBEEF) begin
      errors++;
      $display("FAIL misaligned_read: got cycle %0d error=%b rdata=%h, expected cycle 3 error=0 rdata=a5adbeef", cyc, error, rdata);
    end
    expRdata = 32'hA5ADBEEF;
`endif
  endtask

  task automatic test_errors;
    logic [35:0] vec [4];
    vec[0] = {1'b1, 1'b0, 32'h40, SZ_WORD};
    vec[1] = {1'b0, 1'b1, 32'h40, SZ_BYTE};
    vec[2] = {1'b1, 1'b0, 32'h10, 2'b11};
    vec[3] = {1'b1, 1'b1, 32'h10, SZ_WORD};
    for (int i = 0; i < 4; i++) begin
      issue(0, vec[i][35], vec[i][34], vec[i][33:2], 32'h55, vec[i][1:0]);
      checks++;
      if ({error, ready, memRe, memWe, memBe} !== {4'b1100, 4'h0} || rdata !== expRdata) begin
        errors++;
        $display("FAIL err_vec%0d: got error=%b ready=%b re=%b we=%b be=%h rdata=%h, expected 1 1 0 0 be=0 rdata=%h",
                 i, error, ready, memRe, memWe, memBe, rdata, expRdata);
      end
      @(posedge clk); #1;
      checks++;
      if ({error, ready, memRe, memWe} !== 4'b0000) begin
        errors++;
        $display("FAIL err_pulse%0d: got error=%b ready=%b re=%b we=%b next cycle, expected all 0", i, error, ready, memRe, memWe);
      end
    end
  endtask

  task automatic test_back_to_back;
    int reCnt = 0, rdyCnt = 0, both = 0;
    @(posedge clk); #1;
    addr = 32'h10; size = SZ_WORD; rd = 1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      reCnt += int'(memRe);
      rdyCnt += int'(ready);
      both += int'(memRe && memWe);
    end
    rd = 0;
    checks++;
    if (reCnt !== 3 || rdyCnt !== 3 || both !== 0) begin
      errors++;
      $display("FAIL back_to_back: got re=%0d ready=%0d overlap=%0d in 12 cycles, expected 3 3 0", reCnt, rdyCnt, both);
    end
    checks++;
    if (rdata !== 32'hA5ADBEEF) begin
      errors++;
      $display("FAIL back_to_back_data: got rdata=%h, expected a5adbeef", rdata);
    end
  endtask

  task automatic test_latency4;
    int cyc;
    issue(1, 1, 0, 32'h1040, 32'h0, SZ_WORD);
    checks++;
    if ({memRe4, memAddr4} !== {1'b1, 14'h10}) begin
      errors++;
      $display("FAIL lat4_strobe: got re=%b addr=%h, expected re=1 addr=0010", memRe4, memAddr4);
    end
    waitReady(1, cyc);
    checks++;
    if (cyc !== 6 || rdata4 !== 32'hC0DE_0010) begin
      errors++;
      $display("FAIL lat4_read: got cycle %0d rdata=%h, expected cycle 6 rdata=c0de0010", cyc, rdata4);
    end
    issue(1, 1, 0, 32'h1043, 32'h0, SZ_BYTE);
    waitReady(1, cyc);
    checks++;
    if (cyc !== 6 || rdata4 !== 32'h0000_00C0) begin
      errors++;
      $display("FAIL lat4_byte: got cycle %0d rdata=%h, expected cycle 6 rdata=000000c0", cyc, rdata4);
    end
    issue(1, 1, 0, 32'h0FFC, 32'h0, SZ_WORD);
    checks++;
    if ({error4, ready4, memRe4} !== 3'b110 || rdata4 !== 32'h0000_00C0) begin
      errors++;
      $display("FAIL lat4_below_base: got error=%b ready=%b re=%b rdata=%h, expected 1 1 0 rdata=000000c0", error4, ready4, memRe4, rdata4);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, rdyCnt = 0;
    issue(1, 1, 0, 32'h1044, 32'h0, SZ_WORD);
    @(posedge clk); #1;
    rst = 1;
    #1;
    checks++;
    if ({ready4, error4, memWe4, memRe4, memBe4, memAddr4, memWdata4, rdata4} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got ready=%b error=%b we=%b re=%b be=%h addr=%h wdata=%h rdata=%h, expected all 0",
               ready4, error4, memWe4, memRe4, memBe4, memAddr4, memWdata4, rdata4);
    end
    @(negedge clk) rst = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      rdyCnt += int'(ready4 || error4);
    end
    checks++;
    if (rdyCnt !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_ready: got %0d ready/error pulses after abort, expected 0", rdyCnt);
    end
    issue(1, 1, 0, 32'h1044, 32'h0, SZ_WORD);
    waitReady(1, cyc);
    checks++;
    if (cyc !== 6 || rdata4 !== 32'hC0DE_0011) begin
      errors++;
      $display("FAIL reset_mid_resume: got cycle %0d rdata=%h, expected cycle 6 rdata=c0de0011", cyc, rdata4);
    end
  endtask

  initial begin
    expRdata = 32'h0;
    test_reset;
    test_write_word;
    test_read_word;
    test_byte_write;
    test_subword_read;
    test_misaligned;
    test_errors;
    test_back_to_back;
    test_latency4;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_mem_ctrl.md
BUS_MEM_CTRL -- requirements
Module: bus_mem_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of first mapped word.
REQ-002 SHALL have parameter DEPTH_WORDS, default 16384, number of 32-bit words mapped (power of two).
REQ-003 SHALL have parameter LATENCY, default 1, cycles from mem_re to valid mem_rdata (legal 1..4).
REQ-004 SHALL have port clk, input, 1, single clock; rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports addr input 32, byte address; wdata input 32, store data (low-aligned); rd input 1, read request; wr input 1, write request; size input 2, access size.
REQ-007 SHALL have ports rdata output 32, load data; ready output 1, access complete pulse; error output 1, access fault pulse.
REQ-008 SHALL have ports mem_addr output log2(DEPTH_WORDS), word index; mem_wdata output 32; mem_be output 4, byte enables; mem_we output 1; mem_re output 1; mem_rdata input 32.
REQ-009 SHALL use one clock (clk) and asynchronous active-high reset (rst); polarity and synchronicity are fixed.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, WAIT, DONE, ERR.
REQ-011 In IDLE, rd or wr high at a rising edge SHALL be accepted; addr, wdata and size are registered at acceptance.
REQ-012 Requests while not IDLE SHALL be ignored; the master holds the request until ready or error.
REQ-013 Acceptance SHALL go to ERR if: rd and wr both high; size==2'b11; addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS); or a misaligned access when trapping is enabled (REQ-026).
REQ-014 ERR SHALL assert error and ready together for exactly one cycle, issue no memory strobe, leave rdata unchanged, then return to IDLE.
REQ-015 Valid requests SHALL go to ACCESS, which drives mem_re or mem_we high for exactly one cycle with mem_addr=(addr-BASE_ADDR)>>2.
REQ-016 Byte enables SHALL be: size 00 -> 4'b0001<<addr[1:0]; size 01 -> 4'b0011 if addr[1]==0 else 4'b1100; size 10 -> 4'b1111.
REQ-017 mem_wdata SHALL replicate the byte (size 00) four times and the halfword (size 01) twice; a word is passed unchanged.
REQ-018 A write accepted at edge N SHALL have mem_we high in cycle N+1 and ready high in cycle N+2 (DONE).
REQ-019 A read SHALL pass ACCESS, then WAIT counting LATENCY cycles, capture mem_rdata in cycle N+1+LATENCY, and assert ready in cycle N+2+LATENCY.
REQ-020 Read data SHALL be shifted right by 8*addr[1:0] and zero-extended to 8/16/32 bits per size; sign extension is the core's job.
REQ-021 rdata SHALL hold its value until the next successful read completes.
REQ-022 ready and error SHALL each be single-cycle pulses; mem_re and mem_we SHALL never both be high.
REQ-023 After DONE, the FSM SHALL return to IDLE, so a held request is accepted at most once per completion.

Reset
REQ-024 While rst is high, the FSM SHALL be IDLE, and rdata, ready, error, mem_we, mem_re, mem_be, mem_addr and mem_wdata SHALL be 0.
REQ-025 A reset in mid-access SHALL abort it immediately; no ready or error pulse follows, and a pending write strobe is dropped.

Configuration
REQ-026 With macro MISALIGN_TRAP_EN defined, a halfword with addr[0]!=0 or a word with addr[1:0]!=0 SHALL take the ERR path.
REQ-027 Without MISALIGN_TRAP_EN, the offending low address bits SHALL be treated as zero and the access completes normally.

Structure
REQ-028 A shared package bus_pkg SHALL hold the size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10) and the FSM state enum.
REQ-029 Lane steering (REQ-016, REQ-017, REQ-020) SHALL be a combinational sub-module bus_lane_align, instantiated once.

Verification
REQ-030 Write word 32'hDEADBEEF to 0x10, then read word 0x10 with LATENCY=1: mem_we in cycle N+1 with be=1111, ready at N+2; the read gives ready at N+3 and rdata=32'hDEADBEEF.
REQ-031 Write byte 8'hA5 to 0x13, then read word 0x10: be=4'b1000, mem_wdata=32'hA5A5A5A5, rdata=32'hA5ADBEEF.
REQ-032 Read halfword 0x12 of word 32'h8001_7FFF: rdata=32'h0000_8001.
REQ-033 Word read at 0x11: with MISALIGN_TRAP_EN, error and ready pulse one cycle with no mem_re; without the macro, word 0x10 is returned.
REQ-034 An address of BASE_ADDR+4*DEPTH_WORDS, size 2'b11, or rd and wr together SHALL each give a one-cycle error pulse and no strobe.
REQ-035 Assert rst in the WAIT state with LATENCY=4: all outputs are 0 immediately, with no ready afterwards, and the next request is serviced normally.
